// File: rtl/uart_receiver_frame.sv
// UART receive deframer: majority-vote sampling, false-start rejection, framing/parity errors, EOT detect.
// Optional parity bit: define UART_RX_PARITY_EN.
module uart_receiver_frame #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned EOT_CHAR   = 8'h04,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic                 data_valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 eot,
  output logic                 frame_err,
  output logic                 parity_err
);
  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam int unsigned M  = OVERSAMPLE / 2;
  localparam logic [DATA_BITS-1:0] EOT_W = DATA_BITS'(EOT_CHAR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_s1_q, rxs_q;
  logic [TW-1:0]        tcnt_q, tcnt_d, tnext;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, dout_q, dout_d;
  logic [1:0]           smp_q, smp_d;
  logic                 perr_q;
  logic                 dv_q, dv_d, eot_q, eot_d, fe_q, fe_d;
  logic                 at_dec, at_end, vote;

  // tcnt holds the index of the last tick processed; the detection tick is index 0
  assign tnext  = (tcnt_q == TW'(OVERSAMPLE - 1)) ? '0 : tcnt_q + TW'(1);
  assign at_dec = baud_tick && (tnext == TW'(M + 1));
  assign at_end = baud_tick && (tnext == TW'(OVERSAMPLE - 1));
  assign vote   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);

`ifdef UART_RX_PARITY_EN
  logic perr_d, pe_q, pe_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      smp_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      eot_q   <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      rx_s1_q <= rx;
      rxs_q   <= rx_s1_q;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      smp_q   <= smp_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      eot_q   <= eot_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pe_q    <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    smp_d   = smp_q;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
`endif
    if (baud_tick && state_q != S_IDLE && state_q != S_BREAK) begin
      tcnt_d = tnext;
      if (tnext == TW'(M - 1)) smp_d[0] = rxs_q;
      if (tnext == TW'(M))     smp_d[1] = rxs_q;
    end
    case (state_q)
      S_IDLE: begin
        if (baud_tick && !rxs_q) begin
          state_d = S_START;
          tcnt_d  = '0;
          bcnt_d  = '0;
`ifdef UART_RX_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      S_START: begin
        if (at_dec && vote) state_d = S_IDLE;
        else if (at_end)    state_d = S_DATA;
      end
      S_DATA: begin
        if (at_dec) sh_d = {vote, sh_q[DATA_BITS-1:1]};
        if (at_end) begin
          bcnt_d = bcnt_q + BW'(1);
          if (bcnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (at_dec) perr_d = vote ^ (^sh_q) ^ PARITY_ODD;
        if (at_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // leaving on a good stop at mid-bit leaves half a bit to resync on the next start edge
        if (at_dec) state_d = vote ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        if (baud_tick && rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifndef UART_RX_PARITY_EN
  assign perr_q = 1'b0;
`endif

  always_comb begin
    dv_d   = 1'b0;
    eot_d  = 1'b0;
    fe_d   = 1'b0;
    dout_d = dout_q;
`ifdef UART_RX_PARITY_EN
    pe_d   = 1'b0;
`endif
    if (state_q == S_STOP && at_dec) begin
      dv_d   = 1'b1;
      dout_d = sh_q;
      fe_d   = !vote;
      eot_d  = (sh_q == EOT_W) && vote && !perr_q;
`ifdef UART_RX_PARITY_EN
      pe_d   = perr_q;
`endif
    end
  end

  assign data_valid = dv_q;
  assign data_out   = dout_q;
  assign eot        = eot_q;
  assign frame_err  = fe_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_receiver_frame.sv
// Directed bench for uart_receiver_frame: frame-level expectation queue checked every cycle.
module tb_uart_receiver_frame;
  logic       clk = 1'b0;
  logic       rst, baud_tick, rx;
  logic       data_valid, eot, frame_err, parity_err;
  logic [7:0] data_out;

  uart_receiver_frame dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
    .data_valid(data_valid), .data_out(data_out), .eot(eot),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

`ifdef UART_RX_PARITY_EN
  localparam int LAT = 1701;
  localparam int NFRAMES = 7;
  localparam int NEOT = 2;
`else
  localparam int LAT = 1541;
  localparam int NFRAMES = 5;
  localparam int NEOT = 1;
`endif

  typedef struct {
    logic [7:0] d;
    logic       eot, fe, pe;
  } exp_t;

  exp_t       q[$];
  int         tests = 0, fails = 0;
  int         nclk = 0, pcnt = 0, drop_cyc = 0;
  int         dv_cnt = 0, eot_cnt = 0, fe_cnt = 0, pe_cnt = 0;
  bit         timing_armed = 0;
  logic [7:0] last_d = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, pcnt);
    end
  endtask

  function automatic exp_t model(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d = d; e.fe = fe; e.pe = pe;
    e.eot = (d == 8'h04) && !fe && !pe;
    return e;
  endfunction

  task automatic step(input logic v);
    @(negedge clk);
    nclk++;
    baud_tick = (nclk % 10 == 0);
    rx = v;
  endtask

  task automatic hold(input logic v, input int n);
    repeat (n) step(v);
  endtask

  task automatic align();
    while (((nclk + 1) % 10) != 0) step(1'b1);
  endtask

  // one frame: start, 8 data LSB first, [parity], stop, then extra low bit periods
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par, input int extra_low);
`ifdef UART_RX_PARITY_EN
    q.push_back(model(d, !stop, bad_par));
`else
    q.push_back(model(d, !stop, 1'b0));
`endif
    align();
    step(1'b0);
    drop_cyc = pcnt;
    hold(1'b0, 159);
    for (int i = 0; i < 8; i++) hold(d[i], 160);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ 1'b0 ^ bad_par, 160);
`endif
    hold(stop, 160);
    if (extra_low > 0) hold(1'b0, extra_low * 160);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    pcnt++;
    if (rst) begin
      last_d = 8'h00;
      chk("reset_outs", {data_valid, eot, frame_err, parity_err, data_out}, 12'h000);
    end else if (data_valid) begin
      dv_cnt++;
      if (eot) eot_cnt++;
      if (frame_err) fe_cnt++;
      if (parity_err) pe_cnt++;
      if (q.size() == 0) begin
        chk("spurious_valid", {24'h0, data_out}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("data", data_out, e.d);
        chk("flags", {eot, frame_err, parity_err}, {e.eot, e.fe, e.pe});
        last_d = e.d;
        if (timing_armed) begin
          timing_armed = 0;
          chk("latency", pcnt - drop_cyc, LAT);
        end
      end
    end else begin
      chk("idle_flags", {eot, frame_err, parity_err}, 3'b000);
      chk("hold_data", data_out, last_d);
    end
  end

  initial begin
    rst = 1'b1; rx = 1'b1; baud_tick = 1'b0;
    hold(1'b1, 5);
    chk("rst_vals", {data_valid, eot, frame_err, parity_err, data_out}, 12'h000);
    rst = 1'b0;
    hold(1'b1, 50);

    timing_armed = 1;
    send_frame(8'h9A, 1'b1, 1'b0, 0);
    chk("pin_9a", data_out, 8'h9A);
    send_frame(8'h04, 1'b1, 1'b0, 0);
    hold(1'b1, 100);
    chk("pin_eot_data", data_out, 8'h04);
    chk("pin_eot_cnt", eot_cnt, 1);

    align();
    hold(1'b0, 40);
    hold(1'b1, 300);
    chk("glitch_no_valid", dv_cnt, 2);
    send_frame(8'h9A, 1'b1, 1'b0, 0);
    hold(1'b1, 100);
    chk("after_glitch", dv_cnt, 3);

    send_frame(8'h9A, 1'b0, 1'b0, 3);
    chk("break_single", dv_cnt, 4);
    hold(1'b1, 400);
    chk("pin_fe_cnt", fe_cnt, 1);
    chk("pin_fe_data", data_out, 8'h9A);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h04, 1'b1, 1'b1, 0);
    hold(1'b1, 100);
    chk("pin_pe_cnt", pe_cnt, 1);
    chk("pin_pe_noeot", eot_cnt, 1);
    send_frame(8'h04, 1'b1, 1'b0, 0);
    hold(1'b1, 100);
    chk("pin_par_ok_eot", eot_cnt, 2);
`endif

    align();
    step(1'b0);
    hold(1'b0, 159);
    for (int i = 0; i < 4; i++) hold(i[0] ? 1'b1 : 1'b0, 160);
    rst = 1'b1;
    hold(1'b1, 5);
    rst = 1'b0;
    chk("rst_dout", data_out, 8'h00);
    hold(1'b1, 200);
    send_frame(8'h9A, 1'b1, 1'b0, 0);
    hold(1'b1, 300);

    chk("queue_drained", q.size(), 0);
    chk("total_valid", dv_cnt, NFRAMES);
    chk("total_eot", eot_cnt, NEOT);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_receiver_frame.md
# uart_receiver_frame

Parametrised UART receive deframer, successor to the single-bit receiver in the UART path. Consumes the oversampling `baud_tick` strobe and the raw `rx` line, and delivers whole characters of `DATA_BITS` width with one-cycle `data_valid`. Adds majority-vote sampling, false-start rejection, framing-error reporting, optional parity checking, and a configurable end-of-transmission character. It sits between the baud generator and the RSA command/operand loader.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..9, sent LSB first.
- `OVERSAMPLE`, 16: `baud_tick` strobes per bit period; even, >= 4.
- `EOT_CHAR`, 8'h04: character that raises `eot`; compared on the low `DATA_BITS` bits.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; used only with `UART_RX_PARITY_EN`.
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `baud_tick` in 1: one-clock strobe at OVERSAMPLE x bit rate.
- `rx` in 1: asynchronous serial line; idles high.
- `data_valid` out 1: one-cycle pulse; a character is on `data_out`.
- `data_out` out DATA_BITS: last received character; held until the next `data_valid`.
- `eot` out 1: pulses with `data_valid` when `data_out == EOT_CHAR` and there are no errors.
- `frame_err` out 1: pulses with `data_valid` when the stop bit is sampled 0.
- `parity_err` out 1: pulses with `data_valid` on parity mismatch; constant 0 without the macro.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized `rxs`.
- Tick counter `tcnt` has width $clog2(OVERSAMPLE) and advances only on `baud_tick`. Bit counter has width $clog2(DATA_BITS+1).
- Bit value is the majority of `rxs` captured on ticks M-1, M and M+1, where M = OVERSAMPLE/2. The decision point is tick M+1.
- States:
  - IDLE: on `baud_tick` with `rxs`=0, go to START with `tcnt`=0. This tick is tick 0 of the start bit.
  - START: at the decision point, a vote of 1 returns to IDLE (glitch; no output). Otherwise, at tick OVERSAMPLE-1 go to DATA with `tcnt`=0.
  - DATA: at each decision point, shift the vote into the shift register MSB, so bits are taken LSB first. Bit periods end at tick OVERSAMPLE-1. After DATA_BITS periods go to PARITY if the macro is defined, otherwise to STOP.
  - PARITY: the vote is checked against the XOR of the data bits XOR PARITY_ODD. Then go to STOP.
  - STOP: at the decision point, load `data_out` and pulse the outputs. A vote of 1 goes to IDLE immediately, half a bit early, for resynchronisation. A vote of 0 sets `frame_err` and goes to BREAK.
  - BREAK: wait for a `baud_tick` with `rxs`=1, then go to IDLE. No start is detected while in BREAK.
- `data_out` is loaded even on error. `eot` is suppressed when `frame_err` or `parity_err` is set.

## Timing
- Reset values: `data_valid`=0, `eot`=0, `frame_err`=0, `parity_err`=0, `data_out`=0, state IDLE, counters 0.
- Start detection lags the `rx` falling edge by 2 clk of synchronizer delay plus the time to the next `baud_tick`.
- With P = 1 if the macro is defined, else 0, the outputs pulse on the clk after tick (1+DATA_BITS+P)·OVERSAMPLE + M+1, counted from the detection tick.
- For 8N1 with OVERSAMPLE=16 that is tick 153. With `baud_tick` every 10 clk, that is about 1530 clk.
- All pulse outputs are registered, exactly one clk wide, and coincident.
- Back-to-back frames are supported: a new start bit can be detected on the first `baud_tick` after STOP returns to IDLE.
- `rst` asserted mid-frame aborts the frame with no pulse. `rst` overrides a simultaneous `baud_tick`.
- A `baud_tick` held high continuously is legal; it oversamples at the clk rate.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists and one parity bit follows the data. `parity_err` is active, with parity selected by `PARITY_ODD`.
- `UART_RX_PARITY_EN` undefined: no PARITY state and frames are xN1. `parity_err` is tied to 0 and `PARITY_ODD` is ignored.

## Test plan
- Defaults, `baud_tick` every 10 clk, 1600 ns bits: send data bits 0,1,0,1,1,0,0,1. Expect `data_out`=8'h9A with one `data_valid`, and `eot`=0, `frame_err`=0.
- Send 0x04 after 0x9A: expect `data_valid` with `data_out`=8'h04 and `eot`=1 in the same cycle.
- Pulse `rx` low for 40 clk (4 ticks): expect no `data_valid` and a return to IDLE. A following valid frame 0x9A is still received.
- Send 0x9A with the stop bit 0, then hold `rx` low for 3 bit times: expect `data_out`=8'h9A, `frame_err`=1, a single pulse, and no spurious frame before `rx` returns high.
- With `UART_RX_PARITY_EN` and `PARITY_ODD`=0, send 0x04 with parity bit 0 (wrong): expect `parity_err`=1 and `eot`=0. The same frame with parity bit 1 gives `eot`=1.
- Assert `rst` after the 4th data bit of a frame, release it, then send 0x9A: expect no pulse for the aborted frame, then 0x9A received normally.
